// File: rtl/jk_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : jk_pkg                                                     |
// | Description : Shared mode encoding for the JK-cell register family.      |
// |               mode_t is the 2-bit operating mode; MODE_* are its values. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package jk_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD  = 2'b00;
  localparam mode_t MODE_JK    = 2'b01;
  localparam mode_t MODE_COUNT = 2'b10;
  localparam mode_t MODE_LOAD  = 2'b11;

endpackage : jk_pkg
`default_nettype wire

// File: rtl/jk_cell.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : jk_cell                                                    |
// | Description : Single JK storage bit, updated on the falling clock edge,  |
// |               with asynchronous active-low clear.                        |
// | Ports       : clk   - clock (falling edge active)                        |
// |               CLR_n - asynchronous clear, active low                     |
// |               j, k  - JK inputs (00 hold, 01 clear, 10 set, 11 toggle)   |
// |               q     - stored bit                                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module jk_cell (
  input  logic clk,
  input  logic CLR_n,
  input  logic j,
  input  logic k,
  output logic q
);

  logic r_q;

  always_ff @(negedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      r_q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        2'b11:   r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign q = r_q;

endmodule : jk_cell
`default_nettype wire

// File: rtl/jk_counter_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : jk_counter_reg                                             |
// | Description : WIDTH-bit register built from jk_cell bits. Modes: HOLD,   |
// |               per-bit JK, modulo-(MAX_COUNT+1) up/down COUNT, LOAD.      |
// |               TC is a registered one-cycle terminal-count pulse.         |
// |               Build option JKCNT_SATURATE_EN: COUNT saturates at the     |
// |               ends instead of wrapping (TC flags each blocked step).     |
// | Ports       : clk        - clock, falling edge active                    |
// |               CLR_n      - asynchronous clear, active low                |
// |               mode       - 00 HOLD, 01 JK, 10 COUNT, 11 LOAD             |
// |               J, K       - per-bit JK inputs (JK mode)                   |
// |               D          - parallel load value (LOAD mode)               |
// |               en, up     - count enable / direction (COUNT mode)         |
// |               Q          - register contents                             |
// |               TC         - terminal-count pulse                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module jk_counter_reg
  import jk_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             CLR_n,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] D,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] Q,
  output logic             TC
);

  localparam logic [WIDTH-1:0] c_max_count = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_tc_next;
  logic             r_tc;

  // Next count value and TC for the current Q. Only meaningful in COUNT
  // mode with en high; otherwise w_next == Q so the cells see J=K=0.
  always_comb begin
    w_next    = Q;
    w_tc_next = 1'b0;
    if (mode == MODE_COUNT && en) begin
      if (up) begin
        if (Q >= c_max_count) begin
`ifdef JKCNT_SATURATE_EN
          w_next    = c_max_count;
`else
          w_next    = '0;
`endif
          w_tc_next = 1'b1;
        end else begin
          w_next = Q + 1'b1;
        end
      end else begin
        if (Q == '0) begin
`ifdef JKCNT_SATURATE_EN
          w_next    = '0;
`else
          w_next    = c_max_count;
`endif
          w_tc_next = 1'b1;
        end else if (Q > c_max_count) begin
          // Out-of-range value (reachable via LOAD) snaps back into range.
          w_next = c_max_count;
        end else begin
          w_next = Q - 1'b1;
        end
      end
    end
  end

  // Map each mode onto per-cell JK controls.
  always_comb begin
    w_j = '0;
    w_k = '0;
    case (mode)
      MODE_JK: begin
        w_j = J;
        w_k = K;
      end
      MODE_LOAD: begin
        w_j = D;
        w_k = ~D;
      end
      MODE_COUNT: begin
        // Toggle exactly the bits that differ between Q and the next count.
        w_j = Q ^ w_next;
        w_k = Q ^ w_next;
      end
      default: begin
        w_j = '0;
        w_k = '0;
      end
    endcase
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .CLR_n (CLR_n),
      .j     (w_j[gi]),
      .k     (w_k[gi]),
      .q     (Q[gi])
    );
  end

  always_ff @(negedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      r_tc <= 1'b0;
    end else begin
      r_tc <= w_tc_next;
    end
  end

  assign TC = r_tc;

endmodule : jk_counter_reg
`default_nettype wire
